// File: rtl/ped_request_latch_pkg.sv
// Shared constants, channel-state encoding and helpers for the pedestrian request latch.
package ped_request_latch_pkg;

   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned TIME_W = 6;

   localparam logic [TIME_W-1:0] WAIT_MAX = TIME_W'(63);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SERVED  = 2'd2
   } ch_state_e;

   // Saturating increment of a wait-time counter.
   function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
      return (v == WAIT_MAX) ? v : v + TIME_W'(1);
   endfunction

endpackage

// File: rtl/ped_request_latch_if.sv
// Button/ack inputs and request/status outputs of the pedestrian request latch.
interface ped_request_latch_if #(
   parameter int unsigned NUM_XWALK = 4
);
   import ped_request_latch_pkg::*;

   logic [NUM_XWALK-1:0] btn;
   logic [NUM_XWALK-1:0] ack;
   logic [NUM_XWALK-1:0] req;
   logic [NUM_XWALK-1:0] btn_clean;
   logic                 any_req;
   logic [TIME_W-1:0]    max_wait;

   modport master (
      output btn, ack,
      input  req, btn_clean, any_req, max_wait
   );

   modport slave (
      input  btn, ack,
      output req, btn_clean, any_req, max_wait
   );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-mismatch debouncer for one button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic btn_clean
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;

   // Accept the synchronized level only after DEBOUNCE_CYC consecutive mismatching cycles.
   always_comb begin
      sync_d  = {sync_q[0], btn};
      cnt_d   = '0;
      clean_d = clean_q;
      if (sync_q[1] != clean_q) begin
         if (cnt_q == CNT_LAST) begin
            clean_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer, counter and accepted-level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign btn_clean = clean_q;

endmodule

// File: rtl/ped_request_latch.sv
// Latches debounced crosswalk button presses until the controller acknowledges them,
// and reports how long the oldest outstanding request has waited.
module ped_request_latch
   import ped_request_latch_pkg::*;
#(
   parameter int unsigned NUM_XWALK    = 4,
   parameter int unsigned DEBOUNCE_CYC = 20,
   parameter int unsigned TICK_CYC     = CLK_HZ
) (
   input  logic               clk,
   input  logic               rst_n,
   ped_request_latch_if.slave bus
);

   localparam int unsigned PRESC_W = $clog2(TICK_CYC + 1);

   logic [NUM_XWALK-1:0] clean;
   logic [NUM_XWALK-1:0] clean_prev_q, clean_prev_d;
   ch_state_e            state_q [NUM_XWALK];
   ch_state_e            state_d [NUM_XWALK];
   logic [TIME_W-1:0]    wait_q  [NUM_XWALK];
   logic [TIME_W-1:0]    wait_d  [NUM_XWALK];
   logic [NUM_XWALK-1:0] req_q, req_d;
   logic                 any_req_q, any_req_d;
   logic [TIME_W-1:0]    max_wait_q, max_wait_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 sec_tick;

   for (genvar i = 0; i < NUM_XWALK; i++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn      (bus.btn[i]),
         .btn_clean(clean[i])
      );
   end

   // Free-running one-second prescaler.
   always_comb begin
      sec_tick = (presc_q == PRESC_W'(TICK_CYC - 1));
      presc_d  = sec_tick ? '0 : presc_q + PRESC_W'(1);
   end

   // Per-channel request FSMs, wait counters and the registered status outputs.
   always_comb begin
      clean_prev_d = clean;
      req_d        = '0;
      max_wait_d   = '0;
      for (int i = 0; i < NUM_XWALK; i++) begin
         state_d[i] = state_q[i];
         wait_d[i]  = '0;
         case (state_q[i])
            ST_IDLE:    if (clean[i] && !clean_prev_q[i]) state_d[i] = ST_PENDING;
            ST_PENDING: if (bus.ack[i])                   state_d[i] = ST_SERVED;
            ST_SERVED:  if (!clean[i])                    state_d[i] = ST_IDLE;
            default:                                      state_d[i] = ST_IDLE;
         endcase
         // Counter restarts from zero on entry; only ages while the request stays pending.
         if (state_q[i] == ST_PENDING && state_d[i] == ST_PENDING) begin
            wait_d[i] = sec_tick ? sat_inc(wait_q[i]) : wait_q[i];
         end
         req_d[i] = (state_d[i] == ST_PENDING);
         if (req_d[i] && (wait_d[i] > max_wait_d)) begin
            max_wait_d = wait_d[i];
         end
      end
      any_req_d = |req_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         clean_prev_q <= '0;
         req_q        <= '0;
         any_req_q    <= 1'b0;
         max_wait_q   <= '0;
         for (int i = 0; i < NUM_XWALK; i++) begin
            state_q[i] <= ST_IDLE;
            wait_q[i]  <= '0;
         end
      end else begin
         presc_q      <= presc_d;
         clean_prev_q <= clean_prev_d;
         req_q        <= req_d;
         any_req_q    <= any_req_d;
         max_wait_q   <= max_wait_d;
         for (int i = 0; i < NUM_XWALK; i++) begin
            state_q[i] <= state_d[i];
            wait_q[i]  <= wait_d[i];
         end
      end
   end

   assign bus.req       = req_q;
   assign bus.btn_clean = clean;
   assign bus.any_req   = any_req_q;
   assign bus.max_wait  = max_wait_q;

endmodule

// File: tb/tb_ped_request_latch.sv
// Directed scoreboard bench for ped_request_latch.
module tb_ped_request_latch;
   import ped_request_latch_pkg::*;

   localparam int unsigned NX   = 4;
   localparam int unsigned DEB  = 20;
   localparam int unsigned TICK = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ped_request_latch_if #(.NUM_XWALK(NX)) bus ();

   ped_request_latch #(
      .NUM_XWALK   (NX),
      .DEBOUNCE_CYC(DEB),
      .TICK_CYC    (TICK)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   lat;
   logic sticky;

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0x%0h", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.btn = '0;
      bus.ack = '0;
      rst_n   = 1'b0;
      step(3);

      // Reset state
      expect_val("rst_req", 0);       check(32'(bus.req));
      expect_val("rst_btn_clean", 0); check(32'(bus.btn_clean));
      expect_val("rst_any_req", 0);   check(32'(bus.any_req));
      expect_val("rst_max_wait", 0);  check(32'(bus.max_wait));
      rst_n = 1'b1;
      step(2);

      // Clean press on channel 0: 2 sync + DEB debounce latency, req one cycle later
      expect_val("t1_clean_latency", 2 + DEB);
      bus.btn[0] = 1'b1;
      lat = 0;
      do begin
         step(1);
         lat++;
      end while (bus.btn_clean[0] !== 1'b1 && lat < 60);
      check(32'(lat));
      expect_val("t1_req_before", 0); check(32'(bus.req[0]));
      step(1);
      expect_val("t1_req", 4'b0001);  check(32'(bus.req));
      expect_val("t1_any_req", 1);    check(32'(bus.any_req));
      step(50 - (2 + DEB) - 1);
      bus.btn[0] = 1'b0;
      bus.ack[0] = 1'b1;
      bus.ack[1] = 1'b1;
      step(1);
      bus.ack = '0;
      expect_val("t1_ack_clear", 0);  check(32'(bus.req));
      step(30);

      // Bouncing channel 1 never produces a clean level or request
      sticky = 1'b0;
      for (int c = 0; c < 100; c++) begin
         bus.btn[1] = ((c / 5) % 2 == 0);
         step(1);
         sticky = sticky | bus.btn_clean[1] | bus.req[1];
      end
      bus.btn[1] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step(1);
         sticky = sticky | bus.btn_clean[1] | bus.req[1];
      end
      expect_val("t2_bounce_seen", 0); check(32'(sticky));
      expect_val("t2_req", 0);         check(32'(bus.req));

      // Ack while held on channel 2; re-press only after release plus debounce
      bus.btn[2] = 1'b1;
      step(DEB + 3);
      expect_val("t3_pending", 4'b0100); check(32'(bus.req));
      bus.ack[2] = 1'b1;
      step(1);
      bus.ack[2] = 1'b0;
      expect_val("t3_req_fall", 0);      check(32'(bus.req));
      step(40);
      expect_val("t3_held_no_rereq", 0); check(32'(bus.req));
      bus.ack[2] = 1'b1;
      step(1);
      bus.ack[2] = 1'b0;
      bus.btn[2] = 1'b0;
      step(DEB + 8);
      expect_val("t3_released_clean", 0); check(32'(bus.btn_clean));
      bus.btn[2] = 1'b1;
      step(DEB + 2);
      expect_val("t3_repress_clean", 1); check(32'(bus.btn_clean[2]));
      expect_val("t3_repress_req0", 0);  check(32'(bus.req));
      step(1);
      expect_val("t3_repress_req", 4'b0100); check(32'(bus.req));
      bus.ack[2] = 1'b1;
      step(1);
      bus.ack[2] = 1'b0;
      bus.btn[2] = 1'b0;
      step(30);
      expect_val("t3_done", 0); check(32'(bus.req));

      // Wait counter on channel 3: first tick reads 1, then saturates at 63
      bus.btn[3] = 1'b1;
      step(DEB + 3);
      expect_val("t4_pending", 4'b1000); check(32'(bus.req));
      expect_val("t4_wait_entry", 0);    check(32'(bus.max_wait));
      lat = 0;
      while (bus.max_wait == '0 && lat < int'(TICK) + 2) begin
         step(1);
         lat++;
      end
      expect_val("t4_first_tick", 1);         check(32'(bus.max_wait));
      expect_val("t4_tick_in_period", 1);     check(32'(lat >= 1 && lat <= int'(TICK)));
      step(TICK - 1);
      expect_val("t4_hold_one", 1);           check(32'(bus.max_wait));
      step(1);
      expect_val("t4_second_tick", 2);        check(32'(bus.max_wait));
      step(TICK * 61);
      expect_val("t4_reach_63", 63);          check(32'(bus.max_wait));
      step(TICK * 7);
      expect_val("t4_saturate", 63);          check(32'(bus.max_wait));
      bus.ack[3] = 1'b1;
      step(1);
      bus.ack[3] = 1'b0;
      bus.btn[3] = 1'b0;
      expect_val("t4_ack_req", 0);            check(32'(bus.req));
      expect_val("t4_ack_max_wait", 0);       check(32'(bus.max_wait));
      expect_val("t4_ack_any_req", 0);        check(32'(bus.any_req));
      step(30);

      // Press edge and ack in the same cycle on channel 0 (channel 2 pressed too)
      bus.btn[0] = 1'b1;
      bus.btn[2] = 1'b1;
      step(DEB + 2);
      expect_val("t5_clean", 4'b0101); check(32'(bus.btn_clean));
      expect_val("t5_req_before", 0);  check(32'(bus.req));
      bus.ack[0] = 1'b1;
      step(1);
      bus.ack[0] = 1'b0;
      expect_val("t5_req", 4'b0101);   check(32'(bus.req));
      expect_val("t5_any_req", 1);     check(32'(bus.any_req));
      step(5);

      // Reset mid-request with buttons held through reset
      rst_n = 1'b0;
      #1;
      expect_val("t6_rst_req", 0);       check(32'(bus.req));
      expect_val("t6_rst_clean", 0);     check(32'(bus.btn_clean));
      expect_val("t6_rst_any_req", 0);   check(32'(bus.any_req));
      expect_val("t6_rst_max_wait", 0);  check(32'(bus.max_wait));
      step(3);
      expect_val("t6_rst_hold_req", 0);  check(32'(bus.req));
      rst_n = 1'b1;
      step(DEB + 1);
      expect_val("t6_post_clean0", 0);   check(32'(bus.btn_clean));
      expect_val("t6_post_req0", 0);     check(32'(bus.req));
      step(1);
      expect_val("t6_post_clean", 4'b0101); check(32'(bus.btn_clean));
      expect_val("t6_post_req1", 0);        check(32'(bus.req));
      step(1);
      expect_val("t6_new_req", 4'b0101);    check(32'(bus.req));
      expect_val("t6_new_any_req", 1);      check(32'(bus.any_req));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ped_request_latch.md
PED_REQUEST_LATCH -- requirements
Module: ped_request_latch

Interface
REQ-001 The block SHALL have parameter NUM_XWALK, default 4, meaning the number of crosswalk button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 20, meaning the number of consecutive stable clock cycles before a level is accepted (20 ms at 1 kHz).
REQ-003 The block SHALL have parameter TICK_CYC, default 1000, meaning the clock cycles per one-second tick.
REQ-004 clk  input  1  system clock, 1 kHz nominal; single clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn  input  NUM_XWALK  raw pushbutton levels, asynchronous, active-high.
REQ-007 ack  input  NUM_XWALK  per-channel pulse from intersection controller on the first cycle of that crosswalk's walk phase.
REQ-008 req  output  NUM_XWALK  per-channel pending pedestrian request, level.
REQ-009 btn_clean  output  NUM_XWALK  synchronized, debounced button level.
REQ-010 any_req  output  1  OR-reduction of req.
REQ-011 max_wait  output  6  seconds the oldest pending request has waited, saturating.

Function
REQ-012 Each btn bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 btn_clean[i] SHALL change only after the synchronized input differs from btn_clean[i] for DEBOUNCE_CYC consecutive cycles; any mismatch-free cycle restarts the count.
REQ-014 Each channel SHALL run an FSM with states IDLE, PENDING, SERVED.
REQ-015 IDLE -> PENDING on the cycle after a btn_clean[i] rising edge.
REQ-016 PENDING -> SERVED when ack[i] is 1; ack[i] in IDLE or SERVED SHALL be ignored.
REQ-017 SERVED -> IDLE when btn_clean[i] is 0, so a held button cannot re-request.
REQ-018 A btn_clean[i] rising edge while PENDING SHALL have no effect (no double counting).
REQ-019 If ack[i] and a btn_clean[i] rising edge coincide in IDLE, the press SHALL win (-> PENDING).
REQ-020 req[i] SHALL be 1 exactly while channel i is PENDING, registered, with no combinational path from ack to req.
REQ-021 A free-running prescaler SHALL count 0..TICK_CYC-1 and assert an internal one-cycle sec_tick at wrap.
REQ-022 Each channel SHALL keep a 6-bit wait counter, cleared on entry to PENDING, incremented on sec_tick while PENDING, saturating at 63.
REQ-023 max_wait SHALL be the registered maximum of all PENDING channels' wait counters, and 0 when no channel is PENDING.
REQ-024 any_req SHALL be registered and equal to the OR of req on the same cycle.

Reset
REQ-025 While rst_n is 0, all FSMs SHALL be IDLE; req, btn_clean, any_req, max_wait, synchronizers, debounce counters, wait counters, and prescaler SHALL be 0.
REQ-026 Assertion of rst_n mid-request SHALL discard the pending request; a button held through reset SHALL register as a new press only after debounce following release of reset.

Structure
REQ-027 A shared package SHALL hold CLK_HZ = 1000, TIME_W = 6, and the channel-state encoding (IDLE = 0, PENDING = 1, SERVED = 2).
REQ-028 Synchronizer plus debounce SHALL be one sub-module, btn_debounce, instantiated NUM_XWALK times.

Verification
REQ-029 Clean press: btn[0] high 50 cycles -> btn_clean[0] rises 22 cycles after btn (2 sync + 20 debounce) and req[0] and any_req rise 1 cycle later.
REQ-030 Bounce: btn[1] toggling every 5 cycles for 100 cycles, then low -> btn_clean[1] and req[1] stay 0.
REQ-031 Ack while held: req[2] pending, ack[2] pulse, btn held -> req[2] falls the next cycle; a second press is accepted only after release plus 20 stable cycles.
REQ-032 Wait count: req[3] pending for 70 s with no ack -> max_wait reads 1 at the first sec_tick and saturates at 63.
REQ-033 Simultaneous press and ack: channel 0 in IDLE with btn_clean edge and ack[0] in the same cycle -> req[0] = 1.
REQ-034 Reset mid-request: rst_n low for 3 cycles while req = 4'b0101 -> all outputs become 0 immediately and stay 0 until a new debounced press occurs.
